// File: rtl/id_ex_operand_stage_if.sv
// rtl/id_ex_operand_stage_if.sv - decode, forwarding and EX-side signals of the ID/EX operand stage
interface id_ex_operand_stage_if #(
  parameter int XLEN         = 32,
  parameter int ALU_OP_WIDTH = 4,
  parameter int REG_ADDR_W   = 5
);
  logic                    stall;
  logic                    flush;
  logic                    id_valid;
  logic [XLEN-1:0]         id_pc;
  logic [XLEN-1:0]         id_rs1_data;
  logic [XLEN-1:0]         id_rs2_data;
  logic [REG_ADDR_W-1:0]   id_rs1_addr;
  logic [REG_ADDR_W-1:0]   id_rs2_addr;
  logic                    id_rs1_used;
  logic                    id_rs2_used;
  logic [REG_ADDR_W-1:0]   id_rd_addr;
  logic [XLEN-1:0]         id_imm;
  logic [ALU_OP_WIDTH-1:0] id_alu_op;
  logic                    id_src1_sel;
  logic                    id_src2_sel;
  logic                    id_reg_write;
  logic                    id_mem_read;
  logic                    id_mem_write;
  logic                    exmem_reg_write;
  logic [REG_ADDR_W-1:0]   exmem_rd;
  logic [XLEN-1:0]         exmem_result;
  logic                    memwb_reg_write;
  logic [REG_ADDR_W-1:0]   memwb_rd;
  logic [XLEN-1:0]         memwb_result;
  logic                    load_use_stall;
  logic                    ex_valid;
  logic [XLEN-1:0]         alu_src1;
  logic [XLEN-1:0]         alu_src2;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic [XLEN-1:0]         ex_store_data;
  logic [XLEN-1:0]         ex_pc;
  logic [REG_ADDR_W-1:0]   ex_rd;
  logic                    ex_reg_write;
  logic                    ex_mem_read;
  logic                    ex_mem_write;

  // Pipeline/decode side drives instructions and forwarding sources
  modport master (
    output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data,
           id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_rd_addr,
           id_imm, id_alu_op, id_src1_sel, id_src2_sel, id_reg_write,
           id_mem_read, id_mem_write, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  load_use_stall, ex_valid, alu_src1, alu_src2, alu_op, ex_store_data,
           ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );

  // The operand stage itself
  modport slave (
    input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data,
           id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used, id_rd_addr,
           id_imm, id_alu_op, id_src1_sel, id_src2_sel, id_reg_write,
           id_mem_read, id_mem_write, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output load_use_stall, ex_valid, alu_src1, alu_src2, alu_op, ex_store_data,
           ex_pc, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register with EX/MEM and MEM/WB operand forwarding and load-use bubbles
module id_ex_operand_stage #(
  parameter int XLEN         = 32,
  parameter int ALU_OP_WIDTH = 4,
  parameter int REG_ADDR_W   = 5,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD = '0
) (
  input logic clk,
  input logic rst,
  id_ex_operand_stage_if.slave bus
);
  logic                    ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]         pc_q, pc_d;
  logic [XLEN-1:0]         rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]         rs2_data_q, rs2_data_d;
  logic [REG_ADDR_W-1:0]   rs1_addr_q, rs1_addr_d;
  logic [REG_ADDR_W-1:0]   rs2_addr_q, rs2_addr_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]         imm_q, imm_d;
  logic [ALU_OP_WIDTH-1:0] alu_op_q, alu_op_d;
  logic                    src1_sel_q, src1_sel_d;
  logic                    src2_sel_q, src2_sel_d;
  logic                    reg_write_q, reg_write_d;
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;

  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;
  logic            load_use;

  // Operand forwarding: the younger EX/MEM result beats MEM/WB; x0 is never forwarded
  always_comb begin
    fwd1 = rs1_data_q;
    fwd2 = rs2_data_q;
    if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == rs1_addr_q)
      fwd1 = bus.exmem_result;
    else if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == rs1_addr_q)
      fwd1 = bus.memwb_result;
    if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == rs2_addr_q)
      fwd2 = bus.exmem_result;
    else if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == rs2_addr_q)
      fwd2 = bus.memwb_result;
  end

  // A load in EX whose destination the decoding instruction reads cannot be forwarded in time
  always_comb begin
    load_use = ex_valid_q && mem_read_q && rd_q != '0 && bus.id_valid &&
               ((bus.id_rs1_used && bus.id_rs1_addr == rd_q) ||
                (bus.id_rs2_used && bus.id_rs2_addr == rd_q));
  end

  // Next EX contents: flush > stall (hold, refresh operands) > load-use bubble > load from ID
  always_comb begin
    ex_valid_d  = ex_valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    alu_op_d    = alu_op_q;
    src1_sel_d  = src1_sel_q;
    src2_sel_d  = src2_sel_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (bus.flush || (!bus.stall && load_use)) begin
      ex_valid_d  = 1'b0;
      pc_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      rs1_addr_d  = '0;
      rs2_addr_d  = '0;
      rd_d        = '0;
      imm_d       = '0;
      alu_op_d    = ALU_OP_ADD;
      src1_sel_d  = 1'b0;
      src2_sel_d  = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else if (bus.stall) begin
      // Capture forwarded values so a producer retiring during the hold is not lost
      rs1_data_d = fwd1;
      rs2_data_d = fwd2;
    end else begin
      ex_valid_d  = bus.id_valid;
      pc_d        = bus.id_pc;
      rs1_data_d  = bus.id_rs1_data;
      rs2_data_d  = bus.id_rs2_data;
      rs1_addr_d  = bus.id_rs1_addr;
      rs2_addr_d  = bus.id_rs2_addr;
      rd_d        = bus.id_rd_addr;
      imm_d       = bus.id_imm;
      alu_op_d    = bus.id_alu_op;
      src1_sel_d  = bus.id_src1_sel;
      src2_sel_d  = bus.id_src2_sel;
      reg_write_d = bus.id_reg_write;
      mem_read_d  = bus.id_mem_read;
      mem_write_d = bus.id_mem_write;
    end
  end

  // EX register, cleared to a bubble by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      alu_op_q    <= ALU_OP_ADD;
      src1_sel_q  <= 1'b0;
      src2_sel_q  <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      alu_op_q    <= alu_op_d;
      src1_sel_q  <= src1_sel_d;
      src2_sel_q  <= src2_sel_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  assign bus.load_use_stall = load_use;
  assign bus.ex_valid       = ex_valid_q;
  assign bus.alu_src1       = src1_sel_q ? pc_q : fwd1;
  assign bus.alu_src2       = src2_sel_q ? imm_q : fwd2;
  assign bus.alu_op         = alu_op_q;
  assign bus.ex_store_data  = fwd2;
  assign bus.ex_pc          = pc_q;
  assign bus.ex_rd          = rd_q;
  assign bus.ex_reg_write   = ex_valid_q & reg_write_q;
  assign bus.ex_mem_read    = ex_valid_q & mem_read_q;
  assign bus.ex_mem_write   = ex_valid_q & mem_write_q;
endmodule
